// File: rtl/sensor_request_scheduler.sv
// sensor_request_scheduler: routes UART requests to one of NUM_SENSORS channels,
// returns the channel response over a valid/ready handshake and periodically
// re-triggers channels that are in continuous-sensing mode (round-robin).
// Optional build macro: SCHED_TIMEOUT_EN adds a WAIT-state watchdog (TIMEOUT_CYCLES).
module sensor_request_scheduler #(
   parameter int unsigned NUM_SENSORS    = 4,
   parameter int unsigned LOOP_PERIOD    = 100000000,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req_valid,
   input  logic [7:0]               req_command,
   input  logic [7:0]               req_address,
   output logic                     req_ready,
   output logic [NUM_SENSORS-1:0]   sensor_enable,
   output logic [7:0]               sensor_command,
   input  logic [NUM_SENSORS-1:0]   sensor_done,
   input  logic [8*NUM_SENSORS-1:0] sensor_resp_cmd,
   input  logic [8*NUM_SENSORS-1:0] sensor_resp_val,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [7:0]               tx_address,
   output logic [7:0]               tx_command,
   output logic [7:0]               tx_value,
   output logic [NUM_SENSORS-1:0]   loop_active
);

   localparam int unsigned CH_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
   localparam int unsigned LC_W = (LOOP_PERIOD > 1) ? $clog2(LOOP_PERIOD) : 1;
   localparam logic [7:0] BAD_CODE   = 8'hEF;
   localparam logic [7:0] FAULT_CODE = 8'h1F;
   localparam logic [NUM_SENSORS-1:0] ONE = NUM_SENSORS'(1);

   typedef enum logic [1:0] {IDLE, DISPATCH, WAIT, SEND} state_t;

   state_t                        state, state_nxt;
   logic [CH_W-1:0]               ch, ch_nxt;
   logic [7:0]                    cur_cmd, cmd_nxt;
   logic [CH_W-1:0]               last_ch, last_nxt;
   logic [NUM_SENSORS-1:0][7:0]   loop_cmd, lcmd_nxt;
   logic [NUM_SENSORS-1:0]        loop_nxt, enable_nxt;
   logic [7:0]                    scmd_nxt, txa_nxt, txc_nxt, txval_nxt;
   logic                          txv_nxt, ready_nxt, pend_clr;
   logic [LC_W-1:0]               loop_cnt;
   logic                          loop_pending, loop_wrap;
   logic                          rr_found;
   logic [CH_W-1:0]               rr_ch, cand;
   logic                          addr_bad;
   logic [CH_W-1:0]               req_ch;

   assign addr_bad  = (req_address == 8'd0) || (req_address > 8'(NUM_SENSORS));
   assign req_ch    = CH_W'(req_address - 8'd1);
   assign loop_wrap = (loop_cnt == LC_W'(LOOP_PERIOD - 1));

`ifdef SCHED_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0] wait_cnt;
   logic            timeout;

   assign timeout = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts cycles spent waiting for the enabled channel
   always_ff @(posedge clock or posedge reset) begin
      if (reset)              wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + TO_W'(1);
      else                    wait_cnt <= '0;
   end
`endif

   // Round-robin pick of the next looping channel after the last one served
   always_comb begin
      rr_found = 1'b0;
      rr_ch    = last_ch;
      cand     = last_ch;
      for (int unsigned i = 1; i <= NUM_SENSORS; i++) begin
         cand = CH_W'((32'(last_ch) + i) % NUM_SENSORS);
         if (!rr_found && loop_active[cand]) begin
            rr_found = 1'b1;
            rr_ch    = cand;
         end
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_nxt  = state;
      ch_nxt     = ch;
      cmd_nxt    = cur_cmd;
      last_nxt   = last_ch;
      lcmd_nxt   = loop_cmd;
      loop_nxt   = loop_active;
      enable_nxt = sensor_enable;
      scmd_nxt   = sensor_command;
      txv_nxt    = tx_valid;
      txa_nxt    = tx_address;
      txc_nxt    = tx_command;
      txval_nxt  = tx_value;
      pend_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               cmd_nxt = req_command;
               txa_nxt = req_address;
               if (addr_bad) begin
                  txv_nxt   = 1'b1;
                  txc_nxt   = BAD_CODE;
                  txval_nxt = BAD_CODE;
                  state_nxt = SEND;
               end else begin
                  ch_nxt     = req_ch;
                  enable_nxt = ONE << req_ch;
                  scmd_nxt   = req_command;
                  state_nxt  = DISPATCH;
               end
            end else if (loop_pending && rr_found) begin
               ch_nxt     = rr_ch;
               last_nxt   = rr_ch;
               cmd_nxt    = loop_cmd[rr_ch];
               txa_nxt    = 8'(rr_ch) + 8'd1;
               enable_nxt = ONE << rr_ch;
               scmd_nxt   = loop_cmd[rr_ch];
               pend_clr   = 1'b1;
               state_nxt  = DISPATCH;
            end
         end
         DISPATCH: state_nxt = WAIT;
         WAIT: begin
            if (sensor_done[ch]) begin
               enable_nxt = '0;
               txv_nxt    = 1'b1;
               txc_nxt    = sensor_resp_cmd[{ch, 3'b000} +: 8];
               txval_nxt  = sensor_resp_val[{ch, 3'b000} +: 8];
               state_nxt  = SEND;
               case (cur_cmd)
                  8'h03, 8'h04: begin
                     loop_nxt[ch] = 1'b1;
                     lcmd_nxt[ch] = cur_cmd;
                  end
                  8'h05, 8'h06: loop_nxt[ch] = 1'b0;
                  default: ;
               endcase
            end
`ifdef SCHED_TIMEOUT_EN
            else if (timeout) begin
               enable_nxt   = '0;
               txv_nxt      = 1'b1;
               txc_nxt      = FAULT_CODE;
               txval_nxt    = FAULT_CODE;
               loop_nxt[ch] = 1'b0;
               state_nxt    = SEND;
            end
`endif
         end
         SEND: begin
            if (tx_ready) begin
               txv_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      ready_nxt = (state_nxt == IDLE);
   end

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Registered outputs and transaction context
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ch             <= '0;
         cur_cmd        <= '0;
         last_ch        <= CH_W'(NUM_SENSORS - 1);
         loop_cmd       <= '0;
         loop_active    <= '0;
         sensor_enable  <= '0;
         sensor_command <= '0;
         tx_valid       <= 1'b0;
         tx_address     <= '0;
         tx_command     <= '0;
         tx_value       <= '0;
         req_ready      <= 1'b0;
      end else begin
         ch             <= ch_nxt;
         cur_cmd        <= cmd_nxt;
         last_ch        <= last_nxt;
         loop_cmd       <= lcmd_nxt;
         loop_active    <= loop_nxt;
         sensor_enable  <= enable_nxt;
         sensor_command <= scmd_nxt;
         tx_valid       <= txv_nxt;
         tx_address     <= txa_nxt;
         tx_command     <= txc_nxt;
         tx_value       <= txval_nxt;
         req_ready      <= ready_nxt;
      end
   end

   // Continuous-sensing tick: free-runs while any channel loops; ticks merge while busy
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         loop_cnt     <= '0;
         loop_pending <= 1'b0;
      end else if (loop_active == '0) begin
         loop_cnt     <= '0;
         loop_pending <= 1'b0;
      end else if (loop_wrap) begin
         loop_cnt     <= '0;
         loop_pending <= 1'b1;
      end else begin
         loop_cnt <= loop_cnt + LC_W'(1);
         if (pend_clr) loop_pending <= 1'b0;
      end
   end

endmodule
